// File: rtl/freq_gate_mc_if.sv
`timescale 1ns/1ps
// Bus bundle for the multi-channel reciprocal frequency meter: measured signals,
// trigger controls and the packed per-channel M/N results with their status flags.
interface freq_gate_mc_if #(
  parameter int unsigned CH = 2,
  parameter int unsigned W  = 32
);
  logic [CH-1:0]   sig;
  logic            start;
  logic            cont;
  logic [CH*W-1:0] M;
  logic [CH*W-1:0] N;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   timeout;
  logic [CH-1:0]   gate;
  logic            busy;

  modport master (
    output sig, start, cont,
    input  M, N, valid, timeout, gate, busy
  );

  modport slave (
    input  sig, start, cont,
    output M, N, valid, timeout, gate, busy
  );
endinterface

// File: rtl/freq_gate_mc.sv
`timescale 1ns/1ps
// Multi-channel equal-precision frequency meter: a shared preset gate plus one
// edge-aligned actual gate per channel, yielding M reference cycles over N periods.
module freq_gate_mc #(
  parameter int unsigned CH          = 2,
  parameter int unsigned W           = 32,
  parameter int unsigned GATE_CYC    = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
  input  logic          clk_100M,
  input  logic          rst_n,
  freq_gate_mc_if.slave bus
);

  typedef enum logic [1:0] {G_IDLE, G_GATE, G_WAIT} g_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ARM, C_COUNT, C_CLOSE, C_DONE} c_state_t;

  localparam logic [W-1:0] LP_GATE_LAST = W'(GATE_CYC - 1);
  localparam logic [W-1:0] LP_TMO       = W'(TIMEOUT_CYC);

  g_state_t        r_gst;
  g_state_t        w_gst_nxt;
  logic [W-1:0]    r_tcnt;
  logic            w_go;
  logic            w_preset;
  logic            w_busy;
  logic            w_tmo_hit;
  logic            w_all_done;
  logic [CH-1:0]   w_done;
  logic [CH-1:0]   w_valid;
  logic [CH-1:0]   w_tmo;
  logic [CH-1:0]   w_gate;
  logic [CH*W-1:0] w_m;
  logic [CH*W-1:0] w_n;

  // Global controller: state register, next state, outputs
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) r_gst <= G_IDLE;
    else        r_gst <= w_gst_nxt;
  end

  always_comb begin
    w_gst_nxt = r_gst;
    case (r_gst)
      G_IDLE:  if (bus.start || bus.cont)  w_gst_nxt = G_GATE;
      G_GATE:  if (r_tcnt == LP_GATE_LAST) w_gst_nxt = G_WAIT;
      G_WAIT:  if (w_all_done)             w_gst_nxt = G_IDLE;
      default: w_gst_nxt = G_IDLE;
    endcase
  end

  always_comb begin
    w_go      = (r_gst == G_IDLE) && (bus.start || bus.cont);
    w_preset  = (r_gst == G_GATE);
    w_busy    = (r_gst != G_IDLE);
    w_tmo_hit = (r_gst == G_WAIT) && (r_tcnt == LP_TMO);
  end

  // tcnt restarts at 0 on the first preset-gate cycle and runs until idle
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n)               r_tcnt <= '0;
    else if (w_go)            r_tcnt <= '0;
    else if (r_gst != G_IDLE) r_tcnt <= r_tcnt + W'(1);
  end

  assign w_all_done = &w_done;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic         r_s1;
    logic         r_s2;
    logic         r_hist;
    logic         w_edge;
    c_state_t     r_cst;
    c_state_t     w_cst_nxt;
    logic         w_ld;
    logic         w_abort;
    logic         w_arm;
    logic [W-1:0] r_nums;
    logic [W-1:0] r_nin;
    logic [W-1:0] r_m;
    logic [W-1:0] r_n;
    logic         r_valid;
    logic         r_tmo;
    logic         r_gate;

    // Input synchroniser + history flop: rising edge seen 3 cycles after sig
    always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_hist <= 1'b0;
      end else begin
        r_s1   <= bus.sig[k];
        r_s2   <= r_s1;
        r_hist <= r_s2;
      end
    end

    assign w_edge = r_s2 & ~r_hist;

    always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) r_cst <= C_IDLE;
      else        r_cst <= w_cst_nxt;
    end

    always_comb begin
      w_cst_nxt = r_cst;
      w_ld      = 1'b0;
      w_abort   = 1'b0;
      case (r_cst)
        C_IDLE, C_DONE: if (w_go) w_cst_nxt = C_ARM;
        C_ARM: begin
          if (w_preset && w_edge) begin
            w_cst_nxt = C_COUNT;
          end else if (!w_preset) begin
            w_cst_nxt = C_DONE;
            w_abort   = 1'b1;
          end
        end
        C_COUNT: begin
          if (w_tmo_hit) begin
            w_cst_nxt = C_DONE;
            w_abort   = 1'b1;
          end else if (!w_preset) begin
            w_cst_nxt = C_CLOSE;
          end
        end
        C_CLOSE: begin
          if (w_tmo_hit) begin
            w_cst_nxt = C_DONE;
            w_abort   = 1'b1;
          end else if (w_edge) begin
            w_cst_nxt = C_DONE;
            w_ld      = 1'b1;
          end
        end
        default: w_cst_nxt = C_IDLE;
      endcase
    end

    assign w_arm = (r_cst == C_ARM) && w_preset && w_edge;

    // Counting datapath; the closing edge latches pre-increment counts and is not added to N
    always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
        r_nums  <= '0;
        r_nin   <= '0;
        r_m     <= '0;
        r_n     <= '0;
        r_valid <= 1'b0;
        r_tmo   <= 1'b0;
        r_gate  <= 1'b0;
      end else begin
        r_valid <= w_ld;
        r_tmo   <= w_abort;
        if (w_arm) begin
          r_nums <= W'(1);
          r_nin  <= W'(1);
          r_gate <= 1'b1;
        end else if ((r_cst == C_COUNT) || (r_cst == C_CLOSE)) begin
          r_nums <= r_nums + W'(1);
          if ((r_cst == C_COUNT) && w_edge) r_nin <= r_nin + W'(1);
        end
        if (w_ld) begin
          r_m <= r_nums;
          r_n <= r_nin;
        end
        if (w_cst_nxt == C_DONE) r_gate <= 1'b0;
      end
    end

    assign w_done[k]        = (r_cst == C_DONE);
    assign w_valid[k]       = r_valid;
    assign w_tmo[k]         = r_tmo;
    assign w_gate[k]        = r_gate;
    assign w_m[k*W +: W]    = r_m;
    assign w_n[k*W +: W]    = r_n;
  end

  assign bus.M       = w_m;
  assign bus.N       = w_n;
  assign bus.valid   = w_valid;
  assign bus.timeout = w_tmo;
  assign bus.gate    = w_gate;
  assign bus.busy    = w_busy;

endmodule

// File: doc/freq_gate_mc.md
FREQ_GATE_MC -- requirements
Module: freq_gate_mc

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent measured-signal channels (1..8).
REQ-002 SHALL have parameter W, default 32: width of the M/N counters.
REQ-003 SHALL have parameter GATE_CYC, default 100_000_000: preset gate length in clk_100M cycles.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 200_000_000: abort limit in cycles from gate start; TIMEOUT_CYC > GATE_CYC and TIMEOUT_CYC < 2^W.
REQ-005 SHALL have port clk_100M, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port sig, input, CH: asynchronous measured signals, one bit per channel.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that requests one measurement.
REQ-009 SHALL have port cont, input, 1: 1 = continuous back-to-back measurements, 0 = triggered by start.
REQ-010 SHALL have port M, output, CH*W: per-channel reference-clock count; channel k occupies bits [k*W +: W].
REQ-011 SHALL have port N, output, CH*W: per-channel measured-edge count, packed the same way as M.
REQ-012 SHALL have port valid, output, CH: one-cycle pulse per channel when new M/N are latched.
REQ-013 SHALL have port timeout, output, CH: one-cycle pulse per channel when its measurement aborts.
REQ-014 SHALL have port gate, output, CH: per-channel actual gate (high while that channel is counting).
REQ-015 SHALL have port busy, output, 1: high while a measurement is in progress.

Function
REQ-016 SHALL pass each sig bit through a 2-flop synchroniser plus one history flop; a rising edge is sync2=1 and hist=0, giving 3-cycle detection latency.
REQ-017 SHALL use global controller states G_IDLE, G_GATE and G_WAIT.
REQ-018 In G_IDLE, the controller SHALL enter G_GATE on start=1 or cont=1; start while busy SHALL be ignored.
REQ-019 In G_GATE, preset_gate SHALL be 1 for exactly GATE_CYC cycles and the cycle counter tcnt SHALL run from 0; the controller then enters G_WAIT.
REQ-020 In G_WAIT, tcnt SHALL keep incrementing; the controller SHALL return to G_IDLE when every channel is in C_DONE.
REQ-021 busy SHALL be 1 in G_GATE and G_WAIT.
REQ-022 SHALL give each channel states C_IDLE, C_ARM, C_COUNT, C_CLOSE and C_DONE, all entering C_ARM on G_IDLE->G_GATE.
REQ-023 C_ARM: on an edge with preset_gate=1, num_s:=1, num_in:=1, gate:=1 and go to C_COUNT; if preset_gate falls with no edge, pulse timeout and go to C_DONE.
REQ-024 C_COUNT: num_s+1 every cycle and num_in+1 per edge; when preset_gate falls, go to C_CLOSE.
REQ-025 An edge coinciding with the preset_gate fall SHALL be counted in num_in.
REQ-026 C_CLOSE: num_s+1 every cycle; on an edge, latch M:=num_s and N:=num_in (pre-increment values), pulse valid, clear gate and go to C_DONE; that edge SHALL NOT be added to N.
REQ-027 When tcnt reaches TIMEOUT_CYC with a channel in C_COUNT or C_CLOSE, that channel SHALL pulse timeout, clear gate and go to C_DONE, leaving its M/N unchanged.
REQ-028 C_DONE SHALL hold until the next G_GATE entry.
REQ-029 Measurement semantics: M = cycles between the first and closing edges, N = whole periods, f_sig = 100 MHz * N / M.
REQ-030 M/N SHALL change only on that channel's valid cycle, and valid and timeout SHALL never be asserted together on one channel.

Reset
REQ-031 rst_n=0 SHALL immediately force the following: M, N, valid, timeout, gate and busy to 0; all synchroniser and history flops to 0; counters to 0; controller to G_IDLE; channels to C_IDLE.
REQ-032 SHALL perform no measurement after reset release until start or cont.
REQ-033 Reset asserted mid-measurement SHALL produce no valid or timeout pulse.

Verification (CH=2, W=32, GATE_CYC=1000, TIMEOUT_CYC=3000)
REQ-034 Scenario: sig0 period 10 cycles, start pulse -> valid[0] once, M0 = 10*N0, N0 in {100, 101}, gate[0] high at least 1000 cycles.
REQ-035 Scenario: sig0 period 7, sig1 period 13 simultaneously -> independent valid pulses, M0 = 7*N0, M1 = 13*N1, busy falls after the later valid.
REQ-036 Scenario: sig1 held at 0 -> timeout[1] pulse one cycle after preset_gate falls, no valid[1], M1 = N1 = 0.
REQ-037 Scenario: sig0 period 2500 with an edge just inside the gate -> timeout[0] at tcnt = 3000, M0/N0 retain previous values.
REQ-038 Scenario: cont=1 with sig0 period 10 -> three consecutive valid[0] pulses with identical M0/N0; start pulses while busy have no effect.
REQ-039 Scenario: rst_n low during C_COUNT, then start -> outputs 0 during reset, no pulses, and the next measurement matches the REQ-034 result.
